// File: rtl/mm_sorter_pkg.sv
// Shared definitions for the M&M sorter: colour codes, filter selects and
// the colour reader state encodings.
package mm_sorter_pkg;

    // Colour classification results
    localparam logic [2:0] COL_NONE   = 3'd0;
    localparam logic [2:0] COL_RED    = 3'd1;
    localparam logic [2:0] COL_GREEN  = 3'd2;
    localparam logic [2:0] COL_BLUE   = 3'd3;
    localparam logic [2:0] COL_YELLOW = 3'd4;
    localparam logic [2:0] COL_ORANGE = 3'd5;
    localparam logic [2:0] COL_BROWN  = 3'd6;

    // Sensor filter select codes, {S2,S3}
    localparam logic [1:0] FILT_RED   = 2'b00;
    localparam logic [1:0] FILT_GREEN = 2'b11;
    localparam logic [1:0] FILT_BLUE  = 2'b01;
    localparam logic [1:0] FILT_CLEAR = 2'b10;

    // Top-level measurement sequence
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEAS_R,
        ST_MEAS_G,
        ST_MEAS_B,
        ST_CLASSIFY,
        ST_DONE
    } state_e;

    // Phases of one frequency measurement
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_GUARD,
        PH_GATE
    } phase_e;

endpackage

// File: rtl/colour_sensor_reader_if.sv
// Signal bundle between the colour reader and its surroundings (platform 1
// trigger, the sensor itself, the filter selects and platform 2).
interface colour_sensor_reader_if #(parameter int CNT_W = 20);
    import mm_sorter_pkg::*;

    logic             colour_sensor_on;
    logic             sensor_out;
    logic             s2;
    logic             s3;
    logic             busy;
    logic [CNT_W-1:0] red_count;
    logic [CNT_W-1:0] green_count;
    logic [CNT_W-1:0] blue_count;
    logic [2:0]       colour_code;
    logic             colour_valid;
    logic             p2_on;
    state_e           dbg_state;

    // Handshake: colour_valid (and p2_on with it) is a one-cycle pulse with no
    // ready/back-pressure; the consumer must take colour_code and the three
    // counts in the cycle the pulse is high. They then hold until the next
    // pulse. A trigger is accepted only on a 0->1 edge of colour_sensor_on
    // while busy is low.
    modport master (
        input  colour_sensor_on, sensor_out,
        output s2, s3, busy, red_count, green_count, blue_count,
        output colour_code, colour_valid, p2_on, dbg_state
    );

    modport slave (
        output colour_sensor_on, sensor_out,
        input  s2, s3, busy, red_count, green_count, blue_count,
        input  colour_code, colour_valid, p2_on, dbg_state
    );

endinterface

// File: rtl/freq_gate_counter.sv
// Counts rising edges of an asynchronous square wave over a fixed gate window
// that follows a guard delay. A start pulse (re)arms it from any phase; o_done
// pulses on the last gate cycle with o_count holding the final total.
module freq_gate_counter
    import mm_sorter_pkg::*;
#(
    parameter int GUARD_CYCLES = 5_000,
    parameter int GATE_CYCLES  = 500_000,
    parameter int CNT_W        = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sensor,
    input  logic             i_start,
    output logic [CNT_W-1:0] o_count,
    output logic             o_done
);

    localparam int TMR_MAX = (GUARD_CYCLES > GATE_CYCLES) ? GUARD_CYCLES : GATE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] GUARD_LAST = TMR_W'(GUARD_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST  = TMR_W'(GATE_CYCLES - 1);

    logic             r_sync1, r_sync2, r_sync3;
    logic             w_edge;
    phase_e           r_phase, w_phase_nxt;
    logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;

    // Two-flop synchroniser plus one history flop for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_sensor;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_sync3;

    // Saturating increment; the edge in the final gate cycle is included
    assign w_cnt_inc = (w_edge && (r_cnt != {CNT_W{1'b1}})) ? r_cnt + 1'b1 : r_cnt;
    assign o_count   = w_cnt_inc;

    // Phase register, timer and edge counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_IDLE;
            r_tmr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_tmr   <= w_tmr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Guard then gate sequencing; a start overrides so back-to-back filters chain
    always_comb begin
        w_phase_nxt = r_phase;
        w_tmr_nxt   = r_tmr;
        w_cnt_nxt   = r_cnt;
        o_done      = 1'b0;
        case (r_phase)
            PH_GUARD: begin
                if (r_tmr == GUARD_LAST) begin
                    w_phase_nxt = PH_GATE;
                    w_tmr_nxt   = '0;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            PH_GATE: begin
                w_cnt_nxt = w_cnt_inc;
                if (r_tmr == GATE_LAST) begin
                    o_done      = 1'b1;
                    w_phase_nxt = PH_IDLE;
                    w_tmr_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            default: begin
                w_phase_nxt = PH_IDLE;
            end
        endcase
        if (i_start) begin
            w_phase_nxt = PH_GUARD;
            w_tmr_nxt   = '0;
            w_cnt_nxt   = '0;
        end
    end

endmodule

// File: rtl/colour_sensor_reader.sv
// Waits for platform 1 to settle after a new M&M arrives, measures the
// sensor through red, green and blue filters, classifies the colour and
// pulses the result onward together with a start for platform 2.
module colour_sensor_reader
    import mm_sorter_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2_500_000,
    parameter int GUARD_CYCLES  = 5_000,
    parameter int GATE_CYCLES   = 500_000,
    parameter int CNT_W         = 20,
    parameter int DARK_THRESH   = 200
) (
    input logic                   clk,
    input logic                   rst_n,
    colour_sensor_reader_if.master bus
);

    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_CYCLES - 1);
    localparam int XW = CNT_W + 2;

    logic             r_on_q, r_on_qq;
    logic             w_trig;
    state_e           r_state, w_state_nxt;
    logic [ST_W-1:0]  r_tmr, w_tmr_nxt;
    logic             w_start;
    logic             w_gate_done;
    logic [CNT_W-1:0] w_gate_count;
    logic [CNT_W-1:0] r_meas_r, r_meas_g, r_meas_b;
    logic [CNT_W-1:0] r_red, r_green, r_blue;
    logic [2:0]       r_code, w_code;
    logic [1:0]       w_filt;
    logic [XW-1:0]    w_r, w_g, w_b, w_max;
    logic [1:0]       w_arg;

    // Register the trigger once and keep one history bit for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_on_q  <= 1'b0;
            r_on_qq <= 1'b0;
        end else begin
            r_on_q  <= bus.colour_sensor_on;
            r_on_qq <= r_on_q;
        end
    end

    assign w_trig = r_on_q & ~r_on_qq;

    freq_gate_counter #(
        .GUARD_CYCLES (GUARD_CYCLES),
        .GATE_CYCLES  (GATE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_gate (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sensor (bus.sensor_out),
        .i_start  (w_start),
        .o_count  (w_gate_count),
        .o_done   (w_gate_done)
    );

    // State and settle-timer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    // Sequence: settle, three filtered measurements, classify, publish
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trig) begin
                    w_state_nxt = ST_SETTLE;
                    w_tmr_nxt   = '0;
                end
            end
            ST_SETTLE: begin
                if (r_tmr == SETTLE_LAST) begin
                    w_state_nxt = ST_MEAS_R;
                    w_tmr_nxt   = '0;
                    w_start     = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            ST_MEAS_R: begin
                if (w_gate_done) begin
                    w_state_nxt = ST_MEAS_G;
                    w_start     = 1'b1;
                end
            end
            ST_MEAS_G: begin
                if (w_gate_done) begin
                    w_state_nxt = ST_MEAS_B;
                    w_start     = 1'b1;
                end
            end
            ST_MEAS_B: begin
                if (w_gate_done) begin
                    w_state_nxt = ST_CLASSIFY;
                end
            end
            ST_CLASSIFY: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // A trigger edge here is deliberately dropped
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture each gate total; publish all counts with the code when classifying
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meas_r <= '0;
            r_meas_g <= '0;
            r_meas_b <= '0;
            r_red    <= '0;
            r_green  <= '0;
            r_blue   <= '0;
            r_code   <= COL_NONE;
        end else begin
            if (w_gate_done && (r_state == ST_MEAS_R)) r_meas_r <= w_gate_count;
            if (w_gate_done && (r_state == ST_MEAS_G)) r_meas_g <= w_gate_count;
            if (w_gate_done && (r_state == ST_MEAS_B)) r_meas_b <= w_gate_count;
            if (r_state == ST_CLASSIFY) begin
                r_red   <= r_meas_r;
                r_green <= r_meas_g;
                r_blue  <= r_meas_b;
                r_code  <= w_code;
            end
        end
    end

    // Colour decision; widened by two bits so 3*max and 4*x cannot overflow
    always_comb begin
        w_r = XW'(r_meas_r);
        w_g = XW'(r_meas_g);
        w_b = XW'(r_meas_b);
        if ((w_r >= w_g) && (w_r >= w_b)) begin
            w_max = w_r;
            w_arg = 2'd0;
        end else if (w_g >= w_b) begin
            w_max = w_g;
            w_arg = 2'd1;
        end else begin
            w_max = w_b;
            w_arg = 2'd2;
        end
        if (w_max < XW'(DARK_THRESH)) begin
            w_code = COL_BROWN;
        end else if (((w_r << 2) >= ((w_max << 1) + w_max)) &&
                     ((w_g << 2) >= ((w_max << 1) + w_max)) &&
                     ((w_b << 1) < w_max)) begin
            w_code = COL_YELLOW;
        end else if ((w_arg == 2'd0) && ((w_g << 1) >= w_r) && ((w_b << 1) < w_r)) begin
            w_code = COL_ORANGE;
        end else if (w_arg == 2'd0) begin
            w_code = COL_RED;
        end else if (w_arg == 2'd1) begin
            w_code = COL_GREEN;
        end else begin
            w_code = COL_BLUE;
        end
    end

    // Filter select follows the state directly so it switches with the state
    always_comb begin
        case (r_state)
            ST_MEAS_G: w_filt = FILT_GREEN;
            ST_MEAS_B: w_filt = FILT_BLUE;
            default:   w_filt = FILT_RED;
        endcase
    end

    assign bus.s2           = w_filt[1];
    assign bus.s3           = w_filt[0];
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.colour_valid = (r_state == ST_DONE);
    assign bus.p2_on        = (r_state == ST_DONE);
    assign bus.red_count    = r_red;
    assign bus.green_count  = r_green;
    assign bus.blue_count   = r_blue;
    assign bus.colour_code  = r_code;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_colour_sensor_reader.sv
// Bench for colour_sensor_reader: a sensor model reacts to the filter select,
// stimulus pushes expected results, and monitors check the result pulses and
// the filter sequence.
module tb_colour_sensor_reader;
    import mm_sorter_pkg::*;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [2:0]       code;
        logic [CNT_W-1:0] r;
        logic [CNT_W-1:0] g;
        logic [CNT_W-1:0] b;
        logic [31:0]      trig;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    colour_sensor_reader_if #(.CNT_W(CNT_W)) bus ();

    colour_sensor_reader #(
        .SETTLE_CYCLES (10),
        .GUARD_CYCLES  (4),
        .GATE_CYCLES   (100),
        .CNT_W         (CNT_W),
        .DARK_THRESH   (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    exp_t exp_q[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   n_valid = 0;
    int   per_r   = 0;
    int   per_g   = 0;
    int   per_b   = 0;
    logic [1:0] filt_seq [0:2] = '{2'b11, 2'b01, 2'b00};

    task automatic check_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d at cycle %0d", nm, act, lo, hi, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_rng({tag, "_busy"},  int'(bus.busy), 0, 0);
        check_rng({tag, "_s2"},    int'(bus.s2), 0, 0);
        check_rng({tag, "_s3"},    int'(bus.s3), 0, 0);
        check_rng({tag, "_red"},   int'(bus.red_count), 0, 0);
        check_rng({tag, "_green"}, int'(bus.green_count), 0, 0);
        check_rng({tag, "_blue"},  int'(bus.blue_count), 0, 0);
        check_rng({tag, "_code"},  int'(bus.colour_code), 0, 0);
        check_rng({tag, "_valid"}, int'(bus.colour_valid), 0, 0);
        check_rng({tag, "_p2on"},  int'(bus.p2_on), 0, 0);
    endtask

    // ---------------- sensor model ----------------
    initial begin
        int ph;
        int p;
        ph = 0;
        bus.sensor_out = 1'b0;
        forever begin
            @(negedge clk);
            case ({bus.s2, bus.s3})
                2'b00:   p = per_r;
                2'b11:   p = per_g;
                2'b01:   p = per_b;
                default: p = 0;
            endcase
            if (p == 0) begin
                ph = 0;
                bus.sensor_out = 1'b0;
            end else begin
                ph = (ph + 1) % p;
                bus.sensor_out = (ph < p / 2);
            end
        end
    end

    // ---------------- result monitor ----------------
    initial begin
        logic chk_after;
        int   lat;
        chk_after = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_after) begin
                check_rng("valid_one_cycle", int'(bus.colour_valid), 0, 0);
                check_rng("busy_after_done", int'(bus.busy), 0, 0);
                chk_after = 1'b0;
            end
            if (bus.colour_valid) begin
                n_valid++;
                chk_after = 1'b1;
                check_rng("p2_on_with_valid", int'(bus.p2_on), 1, 1);
                check_rng("busy_in_done", int'(bus.busy), 1, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got pulse with code %0d, expected none", bus.colour_code);
                end else begin
                    mon_e = exp_q.pop_front();
                    lat = cyc - int'(mon_e.trig);
                    check_rng("colour_code", int'(bus.colour_code), int'(mon_e.code), int'(mon_e.code));
                    check_rng("red_count", int'(bus.red_count), int'(mon_e.r) - 1, int'(mon_e.r) + 1);
                    check_rng("green_count", int'(bus.green_count), int'(mon_e.g) - 1, int'(mon_e.g) + 1);
                    check_rng("blue_count", int'(bus.blue_count), int'(mon_e.b) - 1, int'(mon_e.b) + 1);
                    check_rng("latency", lat, 323 - 2, 323 + 2);
                end
            end else if (bus.p2_on) begin
                check_rng("p2_on_without_valid", 1, 0, 0);
            end
        end
    end

    // ---------------- filter sequence monitor ----------------
    initial begin
        logic [1:0] prev;
        logic [1:0] cur;
        int idx;
        prev = 2'b00;
        idx  = 0;
        forever begin
            @(negedge clk);
            cur = {bus.s2, bus.s3};
            if (!rst_n) begin
                idx  = 0;
                prev = cur;
            end else if (cur != prev) begin
                check_rng("filter_seq", int'(cur), int'(filt_seq[idx]), int'(filt_seq[idx]));
                idx  = (idx + 1) % 3;
                prev = cur;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_valid(input int start_cnt, input string nm);
        int i;
        for (i = 0; i < 600; i++) begin
            @(negedge clk);
            if (n_valid > start_cnt) break;
        end
        check_rng({nm, "_valid_seen"}, int'(n_valid > start_cnt), 1, 1);
    endtask

    task automatic wait_state(input state_e st, input string nm);
        int i;
        for (i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus.dbg_state == st) break;
        end
        check_rng({nm, "_state_reached"}, int'(bus.dbg_state == st), 1, 1);
    endtask

    task automatic trigger(input int pr, input int pg, input int pb, input logic push,
                           input logic [2:0] code, input int er, input int eg, input int eb);
        exp_t e;
        per_r = pr;
        per_g = pg;
        per_b = pb;
        @(negedge clk);
        bus.colour_sensor_on = 1'b1;
        if (push) begin
            e.code = code;
            e.r    = CNT_W'(er);
            e.g    = CNT_W'(eg);
            e.b    = CNT_W'(eb);
            e.trig = 32'(cyc + 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_mm(input string nm, input int pr, input int pg, input int pb,
                          input logic [2:0] code, input int er, input int eg, input int eb);
        int start_cnt;
        start_cnt = n_valid;
        trigger(pr, pg, pb, 1'b1, code, er, eg, eb);
        wait_valid(start_cnt, nm);
        bus.colour_sensor_on = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int start_cnt;
        bus.colour_sensor_on = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_mm("red",    4, 20, 20, COL_RED,    25,  5,  5);
        run_mm("green", 20,  4, 20, COL_GREEN,   5, 25,  5);
        run_mm("blue",  20, 20,  4, COL_BLUE,    5,  5, 25);
        run_mm("yellow", 4,  4, 20, COL_YELLOW, 25, 25,  5);
        run_mm("orange", 4,  6, 40, COL_ORANGE, 25, 16,  2);
        run_mm("brown",  0,  0,  0, COL_BROWN,   0,  0,  0);

        // Second edge during MEAS_R must not restart or queue anything
        start_cnt = n_valid;
        trigger(4, 20, 20, 1'b1, COL_RED, 25, 5, 5);
        wait_state(ST_MEAS_R, "retrig");
        repeat (20) @(negedge clk);
        check_rng("retrig_counts_hold", int'(bus.green_count), 0, 0);
        bus.colour_sensor_on = 1'b0;
        @(negedge clk);
        bus.colour_sensor_on = 1'b1;
        repeat (2) @(negedge clk);
        check_rng("retrig_busy", int'(bus.busy), 1, 1);
        check_rng("retrig_state", int'(bus.dbg_state), int'(ST_MEAS_R), int'(ST_MEAS_R));
        wait_valid(start_cnt, "retrig");

        // Trigger held high after the result: no new measurement
        repeat (400) @(negedge clk);
        check_rng("held_no_new_valid", n_valid, start_cnt + 1, start_cnt + 1);
        check_rng("held_busy", int'(bus.busy), 0, 0);
        bus.colour_sensor_on = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of the green measurement
        trigger(20, 4, 20, 1'b0, COL_NONE, 0, 0, 0);
        wait_state(ST_MEAS_G, "rst");
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        check_rng("midrst_state", int'(bus.dbg_state), int'(ST_IDLE), int'(ST_IDLE));
        bus.colour_sensor_on = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_mm("after_rst", 20, 4, 20, COL_GREEN, 5, 25, 5);
        repeat (20) @(negedge clk);

        check_rng("queue_drained", exp_q.size(), 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/colour_sensor_reader.md
Name: colour_sensor_reader

Overview:
- Consumer side of the platform-1 "M&M under sensor" strobe: on a new M&M it waits for the platform to settle, then measures a TCS3200-style light-to-frequency sensor through red, green and blue filters in turn.
- Classifies the colour and hands the result onward with a one-cycle valid pulse plus a start pulse for the next sorting stage.
- Sits between the platform-1 motor controller and the platform-2 (sorting chute) controller.

Parameters:
- SETTLE_CYCLES, 2_500_000, wait after trigger before first measurement (50 ms at 50 MHz).
- GUARD_CYCLES, 5_000, dead time after each filter change before counting starts.
- GATE_CYCLES, 500_000, counting window per filter (10 ms).
- CNT_W, 20, width of each edge counter.
- DARK_THRESH, 200, below this maximum channel count the result is brown.

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- colour_sensor_on  in  1  level/strobe from platform 1; a rising edge means a new M&M is in place
- sensor_out  in  1  asynchronous square wave from the sensor; frequency is proportional to intensity
- s2  out  1  filter select bit S2
- s3  out  1  filter select bit S3
- busy  out  1  high from the accepted trigger until the DONE state exits
- red_count  out  CNT_W  last red gate count
- green_count  out  CNT_W  last green gate count
- blue_count  out  CNT_W  last blue gate count
- colour_code  out  3  0 none, 1 red, 2 green, 3 blue, 4 yellow, 5 orange, 6 brown
- colour_valid  out  1  one-cycle pulse when colour_code and the counts are updated
- p2_on  out  1  one-cycle start pulse to platform 2, coincident with colour_valid

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; all counters 0.
  - s2=0, s3=0 (red filter); busy=0.
  - All counts, colour_code, colour_valid and p2_on = 0.
  - Synchroniser and edge-detect flops = 0.
- Input conditioning:
  - sensor_out passes through a 2-FF synchroniser, then a rising-edge detect; each detected edge counts once.
  - colour_sensor_on is registered once and edge-detected. Only the 0->1 transition triggers, so a held level causes no retrigger.
- FSM states, in order IDLE, SETTLE, MEAS_R, MEAS_G, MEAS_B, CLASSIFY, DONE:
  - IDLE: on a trigger edge go to SETTLE, set busy=1, clear the timer.
  - SETTLE: count SETTLE_CYCLES clocks, then go to MEAS_R with {s2,s3}=00.
  - Each MEAS_x state has two phases:
    - Guard phase: GUARD_CYCLES clocks with edges ignored.
    - Gate phase: exactly GATE_CYCLES clocks counting edges.
    - At gate end, latch the internal count into the x_count register and clear the internal counter.
  - Filter codes: MEAS_R {s2,s3}=00; MEAS_G =11; MEAS_B =01. The select changes in the same cycle as the state changes.
  - CLASSIFY: one cycle. The result is registered into colour_code at exit.
  - DONE: one cycle. colour_valid=1, p2_on=1, busy=0 on the next cycle, return to IDLE with {s2,s3}=00.
- Edge counters saturate at 2^CNT_W-1; no wrap.
- Classification, with comparisons in CNT_W+2 bits:
  - max = largest of R, G, B; ties resolve by priority R > G > B.
  - max < DARK_THRESH -> 6 (brown).
  - else 4*R >= 3*max AND 4*G >= 3*max AND 2*B < max -> 4 (yellow).
  - else max is R AND 2*G >= R AND 2*B < R -> 5 (orange).
  - else argmax: R -> 1, G -> 2, B -> 3.
  - Code 0 appears only after reset, before the first classification.
- Triggers arriving while busy=1 are ignored; they are not queued.
- A trigger edge in the same cycle as DONE is also ignored.
- Counts and colour_code hold their values until the next DONE.
- Reset asserted mid-measurement aborts immediately: all outputs return to reset values and no valid pulse is produced.

Decomposition:
- Shared package (mm_sorter_pkg) holds:
  - colour_code constants COL_NONE..COL_BROWN.
  - filter-select constants FILT_RED/GREEN/BLUE/CLEAR (00/11/01/10).
  - the FSM state enumeration.
- One sub-module, freq_gate_counter, is natural:
  - Contains the synchroniser, edge detect, guard/gate timer and saturating counter.
  - Interface: start, count, done.
  - Instantiated once and reused sequentially for R, G and B.

Test Plan:
- Bench parameters: SETTLE=10, GUARD=4, GATE=100, CNT_W=8, DARK=5.
- Reset mid-operation: reset during MEAS_G -> all outputs 0 on the asynchronous assertion; after release, a fresh trigger yields a normal result.
- Red M&M: sensor period 4 clk in red, 20 in green, 20 in blue -> red_count 25±1, green 5±1, blue 5±1, colour_code=1. colour_valid and p2_on are high for exactly 1 cycle, 10+3*(4+100)+1 cycles after the trigger edge (±2 for synchroniser latency).
- Yellow: periods R=4, G=4, B=20 -> counts 25/25/5 -> code 4.
- Orange: periods R=4, G=6, B=40 -> counts 25/16/2 -> code 5.
- Brown: sensor held low in all filters -> counts 0/0/0 -> code 6.
- Retrigger and held trigger:
  - A second colour_sensor_on edge during MEAS_R leaves busy and timing unchanged and produces only one valid pulse.
  - colour_sensor_on held high after the result -> no new measurement.
- Filter sequencing: {s2,s3} steps 00 -> 11 -> 01 at the MEAS_R, MEAS_G and MEAS_B entries and returns to 00 after DONE.
